// File: rtl/lsq_inorder_fsm_if.sv
// Signal bundle between the in-order load/store queue and its neighbours
// (dispatch, AGU, ROB head, data cache, CDB).
interface lsq_inorder_fsm_if #(
    parameter int DEPTH  = 16,
    parameter int ROB_W  = 6,
    parameter int PHYS_W = 6
);
    localparam int IDX_W = $clog2(DEPTH);

    // Enqueue fires on a cycle with enq_valid && enq_ready; agu_valid, flush and
    // dmem_resp are single-cycle pulses without back-pressure; dmem_* requests
    // stay stable from issue until the cycle dmem_resp is seen.
    logic              enq_valid;
    logic              enq_ready;
    logic              enq_is_store;
    logic [2:0]        enq_funct3;
    logic [ROB_W-1:0]  enq_rob;
    logic [PHYS_W-1:0] enq_pd;
    logic [4:0]        enq_rd;
    logic [IDX_W-1:0]  enq_idx;

    logic              agu_valid;
    logic [IDX_W-1:0]  agu_idx;
    logic [31:0]       agu_addr;
    logic [31:0]       agu_wdata;

    logic [ROB_W-1:0]  rob_head;
    logic              flush;

    logic [31:0]       dmem_addr;
    logic [3:0]        dmem_rmask;
    logic [3:0]        dmem_wmask;
    logic [31:0]       dmem_wdata;
    logic              dmem_resp;
    logic [31:0]       dmem_rdata;

    logic              cdb_valid;
    logic [ROB_W-1:0]  cdb_rob;
    logic [PHYS_W-1:0] cdb_pd;
    logic [4:0]        cdb_rd;
    logic [31:0]       cdb_rd_v;
    logic              cdb_exc;

    modport slave (
        input  enq_valid, enq_is_store, enq_funct3, enq_rob, enq_pd, enq_rd,
        output enq_ready, enq_idx,
        input  agu_valid, agu_idx, agu_addr, agu_wdata,
        input  rob_head, flush,
        output dmem_addr, dmem_rmask, dmem_wmask, dmem_wdata,
        input  dmem_resp, dmem_rdata,
        output cdb_valid, cdb_rob, cdb_pd, cdb_rd, cdb_rd_v, cdb_exc
    );

    modport master (
        output enq_valid, enq_is_store, enq_funct3, enq_rob, enq_pd, enq_rd,
        input  enq_ready, enq_idx,
        output agu_valid, agu_idx, agu_addr, agu_wdata,
        output rob_head, flush,
        input  dmem_addr, dmem_rmask, dmem_wmask, dmem_wdata,
        output dmem_resp, dmem_rdata,
        input  cdb_valid, cdb_rob, cdb_pd, cdb_rd, cdb_rd_v, cdb_exc
    );
endinterface

// File: rtl/lsq_inorder_fsm.sv
// In-order load/store queue: circular slot buffer filled at dispatch and by the AGU,
// drained from the head through an IDLE/WAIT/DRAIN cache-access machine.
module lsq_inorder_fsm #(
    parameter int DEPTH  = 16,
    parameter int ROB_W  = 6,
    parameter int PHYS_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    lsq_inorder_fsm_if.slave bus,
    output logic [1:0]       dbg_state
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam logic [IDX_W:0]   CNT_FULL = (IDX_W+1)'(DEPTH);
    localparam logic [IDX_W:0]   CNT_ONE  = (IDX_W+1)'(1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t state;

    logic [DEPTH-1:0]  ent_valid;
    logic [DEPTH-1:0]  ent_addr_ready;
    logic [DEPTH-1:0]  ent_store;
    logic [2:0]        ent_f3    [DEPTH];
    logic [ROB_W-1:0]  ent_rob   [DEPTH];
    logic [PHYS_W-1:0] ent_pd    [DEPTH];
    logic [4:0]        ent_rd    [DEPTH];
    logic [31:0]       ent_addr  [DEPTH];
    logic [31:0]       ent_wdata [DEPTH];

    logic [IDX_W-1:0] head;
    logic [IDX_W-1:0] tail;
    logic [IDX_W:0]   count;

    logic [31:0]       req_addr;
    logic [31:0]       req_wdata;
    logic [3:0]        req_rmask;
    logic [3:0]        req_wmask;
    logic              req_store;
    logic [2:0]        req_f3;
    logic [1:0]        req_off;
    logic [ROB_W-1:0]  req_rob;
    logic [PHYS_W-1:0] req_pd;
    logic [4:0]        req_rd;

    logic [1:0]  h_off;
    logic [2:0]  h_f3;
    logic        h_store;
    logic        head_ready;
    logic        h_misaligned;
    logic [3:0]  h_mask;
    logic [31:0] h_wdata;

    assign h_off   = ent_addr[head][1:0];
    assign h_f3    = ent_f3[head];
    assign h_store = ent_store[head];
    assign h_wdata = ent_wdata[head] << {h_off, 3'b000};

    // Stores may only touch the cache once they are the oldest uncommitted instruction.
    assign head_ready = ent_valid[head] && ent_addr_ready[head] &&
                        (!h_store || (bus.rob_head == ent_rob[head]));

    always_comb begin
        h_misaligned = 1'b0;
        h_mask       = 4'b1111;
        case (h_f3[1:0])
            2'b00: begin
                h_misaligned = 1'b0;
                h_mask       = 4'b0001 << h_off;
            end
            2'b01: begin
                h_misaligned = h_off[0];
                h_mask       = 4'b0011 << h_off;
            end
            default: begin
                h_misaligned = (h_off != 2'b00);
                h_mask       = 4'b1111;
            end
        endcase
    end

    logic enq_fire;
    logic exc_fire;
    logic resp_fire;
    logic pop;

    assign enq_fire  = bus.enq_valid && bus.enq_ready;
    assign exc_fire  = (state == S_IDLE) && head_ready && h_misaligned && !bus.flush && !rst;
    assign resp_fire = (state == S_WAIT) && bus.dmem_resp;
    assign pop       = exc_fire || resp_fire;

    always_ff @(posedge clk) begin
        if (rst || bus.flush) begin
            ent_valid <= '0;
            head      <= '0;
            tail      <= '0;
            count     <= '0;
        end else begin
            if (bus.agu_valid && ent_valid[bus.agu_idx]) begin
                ent_addr[bus.agu_idx]       <= bus.agu_addr;
                ent_wdata[bus.agu_idx]      <= bus.agu_wdata;
                ent_addr_ready[bus.agu_idx] <= 1'b1;
            end
            if (enq_fire) begin
                ent_valid[tail]      <= 1'b1;
                ent_addr_ready[tail] <= 1'b0;
                ent_store[tail]      <= bus.enq_is_store;
                ent_f3[tail]         <= bus.enq_funct3;
                ent_rob[tail]        <= bus.enq_rob;
                ent_pd[tail]         <= bus.enq_pd;
                ent_rd[tail]         <= bus.enq_rd;
                tail                 <= tail + IDX_ONE;
            end
            if (pop) begin
                ent_valid[head] <= 1'b0;
                head            <= head + IDX_ONE;
            end
            if (enq_fire && !pop) begin
                count <= count + CNT_ONE;
            end else if (!enq_fire && pop) begin
                count <= count - CNT_ONE;
            end
        end
    end

    // The request is captured once so the cache sees stable outputs even if the
    // queue is flushed and refilled while the access is still in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            req_addr  <= '0;
            req_wdata <= '0;
            req_rmask <= '0;
            req_wmask <= '0;
            req_store <= 1'b0;
            req_f3    <= '0;
            req_off   <= '0;
            req_rob   <= '0;
            req_pd    <= '0;
            req_rd    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (head_ready && !h_misaligned && !bus.flush) begin
                        state     <= S_WAIT;
                        req_addr  <= {ent_addr[head][31:2], 2'b00};
                        req_rmask <= h_store ? 4'b0000 : h_mask;
                        req_wmask <= h_store ? h_mask : 4'b0000;
                        req_wdata <= h_store ? h_wdata : 32'h0;
                        req_store <= h_store;
                        req_f3    <= h_f3;
                        req_off   <= h_off;
                        req_rob   <= ent_rob[head];
                        req_pd    <= ent_pd[head];
                        req_rd    <= ent_rd[head];
                    end
                end
                S_WAIT: begin
                    if (bus.dmem_resp) begin
                        state     <= S_IDLE;
                        req_addr  <= '0;
                        req_wdata <= '0;
                        req_rmask <= '0;
                        req_wmask <= '0;
                    end else if (bus.flush) begin
                        state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (bus.dmem_resp) begin
                        state     <= S_IDLE;
                        req_addr  <= '0;
                        req_wdata <= '0;
                        req_rmask <= '0;
                        req_wmask <= '0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    logic [7:0]  ld_b;
    logic [15:0] ld_h;
    logic [31:0] ld_val;

    assign ld_b = bus.dmem_rdata[{req_off, 3'b000} +: 8];
    assign ld_h = bus.dmem_rdata[{req_off[1], 4'b0000} +: 16];

    always_comb begin
        case (req_f3)
            3'b000:  ld_val = {{24{ld_b[7]}}, ld_b};
            3'b001:  ld_val = {{16{ld_h[15]}}, ld_h};
            3'b100:  ld_val = {24'h0, ld_b};
            3'b101:  ld_val = {16'h0, ld_h};
            default: ld_val = bus.dmem_rdata;
        endcase
    end

    always_comb begin
        bus.cdb_valid = 1'b0;
        bus.cdb_rob   = '0;
        bus.cdb_pd    = '0;
        bus.cdb_rd    = '0;
        bus.cdb_rd_v  = '0;
        bus.cdb_exc   = 1'b0;
        if (exc_fire) begin
            bus.cdb_valid = 1'b1;
            bus.cdb_rob   = ent_rob[head];
            bus.cdb_exc   = 1'b1;
        end else if (resp_fire && !bus.flush && !rst) begin
            bus.cdb_valid = 1'b1;
            bus.cdb_rob   = req_rob;
            if (!req_store) begin
                bus.cdb_pd   = req_pd;
                bus.cdb_rd   = req_rd;
                bus.cdb_rd_v = ld_val;
            end
        end
    end

    assign bus.enq_ready  = (count != CNT_FULL);
    assign bus.enq_idx    = tail;
    assign bus.dmem_addr  = req_addr;
    assign bus.dmem_rmask = req_rmask;
    assign bus.dmem_wmask = req_wmask;
    assign bus.dmem_wdata = req_wdata;
    assign dbg_state      = state;
endmodule

// File: tb/tb_lsq_inorder_fsm.sv
// Directed bench for lsq_inorder_fsm: a transaction-level queue model checked every
// cycle, plus literal expectations on the hand-worked scenarios.
module tb_lsq_inorder_fsm;
  localparam int DEPTH  = 4;
  localparam int ROB_W  = 6;
  localparam int PHYS_W = 6;

  logic       clk;
  logic       rst;
  logic [1:0] dbg_state;

  lsq_inorder_fsm_if #(.DEPTH(DEPTH), .ROB_W(ROB_W), .PHYS_W(PHYS_W)) bus ();

  lsq_inorder_fsm #(.DEPTH(DEPTH), .ROB_W(ROB_W), .PHYS_W(PHYS_W)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  // ---------------- scoreboard counters ----------------
  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, got, exp);
    end
  endtask

  // ---------------- transaction-level model ----------------
  typedef struct {
    int          slot;
    bit          st;
    logic [2:0]  f3;
    logic [5:0]  rob;
    logic [5:0]  pd;
    logic [4:0]  rd;
    logic [31:0] addr;
    logic [31:0] wdata;
    bit          ar;
  } ent_t;

  ent_t        mq[$];
  int          m_tail  = 0;
  int          m_phase = 0;   // 0 no access, 1 access owed a CDB, 2 access to be discarded
  ent_t        m_cur;
  logic [31:0] m_addr  = '0;
  logic [31:0] m_wdata = '0;
  logic [3:0]  m_rmask = '0;
  logic [3:0]  m_wmask = '0;

  function automatic int nbytes(input logic [2:0] f3);
    if (f3[1:0] == 2'b00) return 1;
    if (f3[1:0] == 2'b01) return 2;
    return 4;
  endfunction

  function automatic bit m_misal(input ent_t e);
    return (int'(e.addr[1:0]) % nbytes(e.f3)) != 0;
  endfunction

  function automatic bit m_head_ready();
    if (mq.size() == 0) return 1'b0;
    return mq[0].ar && (!mq[0].st || (mq[0].rob == bus.rob_head));
  endfunction

  function automatic logic [31:0] load_val(input logic [2:0] f3, input logic [1:0] a,
                                           input logic [31:0] d);
    logic [31:0] v;
    int n;
    n = nbytes(f3);
    if (n == 4) return d;
    v = d >> (8 * int'(a));
    if (n == 1) begin
      v = v & 32'h0000_00FF;
      if (!f3[2] && v[7]) v = v | 32'hFFFF_FF00;
    end else begin
      v = v & 32'h0000_FFFF;
      if (!f3[2] && v[15]) v = v | 32'hFFFF_0000;
    end
    return v;
  endfunction

  always @(posedge clk) begin
    bit   hr;
    bit   pop;
    bit   enq_ok;
    int   a;
    int   n;
    ent_t ne;
    if (rst) begin
      mq.delete();
      m_tail  = 0;
      m_phase = 0;
      m_addr  = '0;
      m_wdata = '0;
      m_rmask = '0;
      m_wmask = '0;
    end else begin
      hr     = m_head_ready();
      enq_ok = bus.enq_valid && (mq.size() < DEPTH);
      pop    = 1'b0;
      if (m_phase == 0) begin
        if (hr && !bus.flush) begin
          if (m_misal(mq[0])) begin
            pop = 1'b1;
          end else begin
            m_cur   = mq[0];
            a       = int'(mq[0].addr[1:0]);
            n       = nbytes(mq[0].f3);
            m_addr  = mq[0].addr & 32'hFFFF_FFFC;
            m_rmask = mq[0].st ? 4'h0 : 4'(((1 << n) - 1) << a);
            m_wmask = mq[0].st ? 4'(((1 << n) - 1) << a) : 4'h0;
            m_wdata = mq[0].st ? (mq[0].wdata << (8 * a)) : 32'h0;
            m_phase = 1;
          end
        end
      end else if (m_phase == 1) begin
        if (bus.dmem_resp) begin
          pop     = 1'b1;
          m_phase = 0;
        end else if (bus.flush) begin
          m_phase = 2;
        end
      end else if (bus.dmem_resp) begin
        m_phase = 0;
      end
      if (m_phase == 0) begin
        m_addr  = '0;
        m_wdata = '0;
        m_rmask = '0;
        m_wmask = '0;
      end
      if (bus.flush) begin
        mq.delete();
        m_tail = 0;
      end else begin
        if (pop) void'(mq.pop_front());
        if (bus.agu_valid) begin
          foreach (mq[i]) begin
            if (mq[i].slot == int'(bus.agu_idx)) begin
              mq[i].addr  = bus.agu_addr;
              mq[i].wdata = bus.agu_wdata;
              mq[i].ar    = 1'b1;
            end
          end
        end
        if (enq_ok) begin
          ne.slot  = m_tail;
          ne.st    = bus.enq_is_store;
          ne.f3    = bus.enq_funct3;
          ne.rob   = bus.enq_rob;
          ne.pd    = bus.enq_pd;
          ne.rd    = bus.enq_rd;
          ne.addr  = '0;
          ne.wdata = '0;
          ne.ar    = 1'b0;
          mq.push_back(ne);
          m_tail = (m_tail + 1) % DEPTH;
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  logic        e_cv;
  logic        e_exc;
  logic [5:0]  e_rob;
  logic [5:0]  e_pd;
  logic [4:0]  e_rd;
  logic [31:0] e_val;

  always @(negedge clk) begin
    if (chk_en) begin
      e_cv = 0; e_exc = 0; e_rob = '0; e_pd = '0; e_rd = '0; e_val = '0;
      if (!bus.flush && !rst) begin
        if (m_phase == 1 && bus.dmem_resp) begin
          e_cv  = 1'b1;
          e_rob = m_cur.rob;
          if (!m_cur.st) begin
            e_pd  = m_cur.pd;
            e_rd  = m_cur.rd;
            e_val = load_val(m_cur.f3, m_cur.addr[1:0], bus.dmem_rdata);
          end
        end else if (m_phase == 0 && m_head_ready() && m_misal(mq[0])) begin
          e_cv  = 1'b1;
          e_exc = 1'b1;
          e_rob = mq[0].rob;
        end
      end
      check("cyc enq_ready",  bus.enq_ready,  (mq.size() != DEPTH));
      check("cyc enq_idx",    bus.enq_idx,    m_tail);
      check("cyc dmem_addr",  bus.dmem_addr,  m_addr);
      check("cyc dmem_rmask", bus.dmem_rmask, m_rmask);
      check("cyc dmem_wmask", bus.dmem_wmask, m_wmask);
      check("cyc dmem_wdata", bus.dmem_wdata, m_wdata);
      check("cyc cdb_valid",  bus.cdb_valid,  e_cv);
      check("cyc cdb_exc",    bus.cdb_exc,    e_exc);
      check("cyc cdb_rob",    bus.cdb_rob,    e_rob);
      check("cyc cdb_pd",     bus.cdb_pd,     e_pd);
      check("cyc cdb_rd",     bus.cdb_rd,     e_rd);
      check("cyc cdb_rd_v",   bus.cdb_rd_v,   e_val);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic enq(input bit st, input logic [2:0] f3, input logic [5:0] rob,
                     input logic [5:0] pd, input logic [4:0] rd);
    bus.enq_valid    = 1'b1;
    bus.enq_is_store = st;
    bus.enq_funct3   = f3;
    bus.enq_rob      = rob;
    bus.enq_pd       = pd;
    bus.enq_rd       = rd;
    tick();
    bus.enq_valid    = 1'b0;
  endtask

  task automatic agu(input logic [1:0] idx, input logic [31:0] addr, input logic [31:0] wdata);
    bus.agu_valid = 1'b1;
    bus.agu_idx   = idx;
    bus.agu_addr  = addr;
    bus.agu_wdata = wdata;
    tick();
    bus.agu_valid = 1'b0;
  endtask

  task automatic wait_req(input string name);
    int k;
    k = 0;
    while (bus.dmem_rmask == 4'h0 && bus.dmem_wmask == 4'h0 && k < 20) begin
      tick();
      k++;
    end
    check({name, " request_seen"}, (k < 20), 1);
  endtask

  task automatic resp_check(input string name, input logic [31:0] data, input bit exp_v,
                            input logic [5:0] rob, input logic [5:0] pd, input logic [31:0] val);
    bus.dmem_resp  = 1'b1;
    bus.dmem_rdata = data;
    #1;
    check({name, " cdb_valid"}, bus.cdb_valid, exp_v);
    if (exp_v) begin
      check({name, " cdb_rob"},  bus.cdb_rob,  rob);
      check({name, " cdb_pd"},   bus.cdb_pd,   pd);
      check({name, " cdb_rd_v"}, bus.cdb_rd_v, val);
    end
    @(posedge clk);
    #1;
    bus.dmem_resp  = 1'b0;
    bus.dmem_rdata = '0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst = 1'b1;
    bus.enq_valid = 0; bus.enq_is_store = 0; bus.enq_funct3 = '0; bus.enq_rob = '0;
    bus.enq_pd = '0; bus.enq_rd = '0; bus.agu_valid = 0; bus.agu_idx = '0;
    bus.agu_addr = '0; bus.agu_wdata = '0; bus.rob_head = '0; bus.flush = 0;
    bus.dmem_resp = 0; bus.dmem_rdata = '0;
    tick();
    chk_en = 1'b1;
    tick();
    rst = 1'b0;

    check("reset enq_ready", bus.enq_ready, 1);
    check("reset enq_idx", bus.enq_idx, 0);
    check("reset rmask", bus.dmem_rmask, 0);
    check("reset cdb_valid", bus.cdb_valid, 0);
    check("reset state", dbg_state, 0);

    // lw rob 3 -> slot 0, addr 0x100
    enq(1'b0, 3'b010, 6'd3, 6'd9, 5'd5);
    agu(2'd0, 32'h0000_0100, 32'h0);
    check("lw not yet issued", bus.dmem_rmask, 4'b0000);
    tick();
    check("lw rmask", bus.dmem_rmask, 4'b1111);
    check("lw addr", bus.dmem_addr, 32'h0000_0100);
    resp_check("lw", 32'hDEAD_BEEF, 1'b1, 6'd3, 6'd9, 32'hDEAD_BEEF);

    // lb at 0x103 -> slot 1
    enq(1'b0, 3'b000, 6'd4, 6'd10, 5'd6);
    agu(2'd1, 32'h0000_0103, 32'h0);
    wait_req("lb");
    check("lb rmask", bus.dmem_rmask, 4'b1000);
    check("lb addr", bus.dmem_addr, 32'h0000_0100);
    resp_check("lb", 32'h8000_0000, 1'b1, 6'd4, 6'd10, 32'hFFFF_FF80);

    // lhu at 0x102 -> slot 2
    enq(1'b0, 3'b101, 6'd5, 6'd11, 5'd7);
    agu(2'd2, 32'h0000_0102, 32'h0);
    wait_req("lhu");
    check("lhu rmask", bus.dmem_rmask, 4'b1100);
    resp_check("lhu", 32'h8000_0000, 1'b1, 6'd5, 6'd11, 32'h0000_8000);

    // sb at 0x201 waits for rob_head -> slot 3
    bus.rob_head = 6'd6;
    enq(1'b1, 3'b000, 6'd7, 6'd12, 5'd8);
    agu(2'd3, 32'h0000_0201, 32'h0000_00AB);
    tick(); tick(); tick();
    check("sb held wmask", bus.dmem_wmask, 4'b0000);
    bus.rob_head = 6'd7;
    wait_req("sb");
    check("sb wmask", bus.dmem_wmask, 4'b0010);
    check("sb wdata", bus.dmem_wdata, 32'h0000_AB00);
    check("sb addr", bus.dmem_addr, 32'h0000_0200);
    resp_check("sb", 32'h0, 1'b1, 6'd7, 6'd0, 32'h0);

    // fill all slots, try one more
    for (int i = 0; i < DEPTH; i++) enq(1'b0, 3'b010, 6'(20 + i), 6'(30 + i), 5'(i + 1));
    check("full enq_ready", bus.enq_ready, 0);
    enq(1'b0, 3'b010, 6'd40, 6'd41, 5'd9);
    check("full extra ignored idx", bus.enq_idx, 0);
    check("full still full", bus.enq_ready, 0);
    agu(2'd0, 32'h0000_0300, 32'h0);
    wait_req("pop_one");
    resp_check("pop_one", 32'h1234_5678, 1'b1, 6'd20, 6'd30, 32'h1234_5678);
    check("after pop enq_ready", bus.enq_ready, 1);
    check("after pop enq_idx", bus.enq_idx, 0);
    enq(1'b0, 3'b010, 6'd24, 6'd34, 5'd10);
    check("wrap enq_idx", bus.enq_idx, 1);
    check("wrap full again", bus.enq_ready, 0);
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    check("idle flush enq_idx", bus.enq_idx, 0);
    check("idle flush enq_ready", bus.enq_ready, 1);

    // misaligned lw -> exception, no cache access
    enq(1'b0, 3'b010, 6'd12, 6'd13, 5'd11);
    agu(2'd0, 32'h0000_0102, 32'h0);
    check("mis cdb_valid", bus.cdb_valid, 1);
    check("mis cdb_exc", bus.cdb_exc, 1);
    check("mis cdb_rob", bus.cdb_rob, 6'd12);
    check("mis cdb_pd", bus.cdb_pd, 0);
    check("mis rmask", bus.dmem_rmask, 0);
    tick();
    check("mis one cycle", bus.cdb_valid, 0);
    check("mis popped idx", bus.enq_idx, 1);

    // flush during WAIT -> drain
    enq(1'b0, 3'b010, 6'd13, 6'd14, 5'd12);
    agu(2'd1, 32'h0000_0400, 32'h0);
    wait_req("drain");
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    check("drain enq_idx", bus.enq_idx, 0);
    check("drain rmask held", bus.dmem_rmask, 4'b1111);
    tick(); tick();
    resp_check("drain", 32'h5555_5555, 1'b0, 6'd0, 6'd0, 32'h0);
    check("drain done rmask", bus.dmem_rmask, 0);

    // flush on the response cycle
    enq(1'b0, 3'b010, 6'd14, 6'd15, 5'd13);
    agu(2'd0, 32'h0000_0500, 32'h0);
    wait_req("flush_resp");
    bus.flush = 1'b1;
    resp_check("flush_resp", 32'h6666_6666, 1'b0, 6'd0, 6'd0, 32'h0);
    bus.flush = 1'b0;
    check("flush_resp enq_idx", bus.enq_idx, 0);
    check("flush_resp rmask", bus.dmem_rmask, 0);

    // pop of the last entry with a simultaneous enqueue
    enq(1'b0, 3'b010, 6'd15, 6'd16, 5'd7);
    agu(2'd0, 32'h0000_0600, 32'h0);
    wait_req("enq_pop");
    bus.enq_valid = 1'b1; bus.enq_is_store = 1'b0; bus.enq_funct3 = 3'b001;
    bus.enq_rob = 6'd16; bus.enq_pd = 6'd17; bus.enq_rd = 5'd8;
    resp_check("enq_pop", 32'h0000_F0F0, 1'b1, 6'd15, 6'd16, 32'h0000_F0F0);
    bus.enq_valid = 1'b0;
    check("enq_pop enq_idx", bus.enq_idx, 2);
    agu(2'd1, 32'h0000_0606, 32'h0);
    wait_req("lh");
    check("lh rmask", bus.dmem_rmask, 4'b1100);
    check("lh addr", bus.dmem_addr, 32'h0000_0604);
    resp_check("lh", 32'h8001_0000, 1'b1, 6'd16, 6'd17, 32'hFFFF_8001);

    // sh at 0x20A
    bus.rob_head = 6'd30;
    enq(1'b1, 3'b001, 6'd30, 6'd18, 5'd9);
    agu(2'd2, 32'h0000_020A, 32'h1234_BEEF);
    wait_req("sh");
    check("sh wmask", bus.dmem_wmask, 4'b1100);
    check("sh wdata", bus.dmem_wdata, 32'hBEEF_0000);
    resp_check("sh", 32'h0, 1'b1, 6'd30, 6'd0, 32'h0);

    tick(); tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
